// File: rtl/console_writer.sv
// Writer side of the text display: places characters into the character buffer,
// tracks the text cursor and walks clear passes over one row or the whole screen.
module console_writer #(
  parameter int          COLS           = 40,
  parameter int          ROWS           = 30,
  parameter int          ADDR_W         = 11,
  parameter logic [11:0] CLR_CHAR_COLOR = 12'hFFF,
  parameter logic [11:0] CLR_BACK_COLOR = 12'h000
) (
  input  logic              pix_clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  input  logic [6:0]        in_char,
  input  logic [11:0]       in_char_color,
  input  logic [11:0]       in_back_color,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [30:0]       wr_data,
  output logic [5:0]        cursor_x,
  output logic [4:0]        cursor_y,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, CLR_ROW, CLR_ALL} state_t;

  // One extra bit so the counter can hold the cell count itself as its end marker.
  localparam int                CNT_W      = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  ROW_CELLS  = CNT_W'(COLS);
  localparam logic [CNT_W-1:0]  ALL_CELLS  = CNT_W'(COLS * ROWS);
  localparam logic [5:0]        LAST_COL   = 6'(COLS - 1);
  localparam logic [4:0]        LAST_ROW   = 5'(ROWS - 1);
  localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COLS);
  localparam logic [30:0]       CLEAR_CELL = {7'h20, CLR_CHAR_COLOR, CLR_BACK_COLOR};

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [5:0]        cursor_x_next;
  logic [4:0]        cursor_y_next;
  logic              wr_en_next;
  logic [ADDR_W-1:0] wr_addr_next;
  logic [30:0]       wr_data_next;
  logic [4:0]        next_row;
  logic              accept;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] y,
                                                  input logic [ADDR_W-1:0] x);
    return ADDR_W'(y) * COLS_A + x;
  endfunction

  assign in_ready = (state == IDLE) && en && !rst;
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign next_row = (cursor_y == LAST_ROW) ? 5'd0 : cursor_y + 5'd1;

  // NOTE: every variable gets a default before the case so no path leaves one unassigned, which would infer a latch.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    cursor_x_next = cursor_x;
    cursor_y_next = cursor_y;
    wr_en_next    = 1'b0;
    wr_addr_next  = wr_addr;
    wr_data_next  = wr_data;

    case (state)
      IDLE: begin
        if (accept) begin
          if (in_char >= 7'h20 && in_char <= 7'h7E) begin
            wr_en_next   = 1'b1;
            wr_addr_next = cell_addr(cursor_y, ADDR_W'(cursor_x));
            wr_data_next = {in_char, in_char_color, in_back_color};
            if (cursor_x == LAST_COL) begin
              cursor_x_next = 6'd0;
              cursor_y_next = next_row;
              state_next    = CLR_ROW;
              cnt_next      = '0;
            end else begin
              cursor_x_next = cursor_x + 6'd1;
            end
          end else begin
            case (in_char)
              7'h0A: begin
                cursor_x_next = 6'd0;
                cursor_y_next = next_row;
                state_next    = CLR_ROW;
                cnt_next      = '0;
              end
              7'h0D: cursor_x_next = 6'd0;
              7'h08: begin
                if (cursor_x != 6'd0) begin
                  cursor_x_next = cursor_x - 6'd1;
                  wr_en_next    = 1'b1;
                  wr_addr_next  = cell_addr(cursor_y, ADDR_W'(cursor_x - 6'd1));
                  wr_data_next  = CLEAR_CELL;
                end
              end
              7'h0C: begin
                // Cell 0 is written on the accepting edge, so the walk resumes at 1.
                cursor_x_next = 6'd0;
                cursor_y_next = 5'd0;
                state_next    = CLR_ALL;
                cnt_next      = CNT_W'(1);
                wr_en_next    = 1'b1;
                wr_addr_next  = '0;
                wr_data_next  = CLEAR_CELL;
              end
              default: ;
            endcase
          end
        end
      end

      CLR_ROW: begin
        if (cnt == ROW_CELLS) begin
          state_next = IDLE;
        end else begin
          wr_en_next   = 1'b1;
          wr_addr_next = cell_addr(cursor_y, ADDR_W'(cnt));
          wr_data_next = CLEAR_CELL;
          cnt_next     = cnt + CNT_W'(1);
        end
      end

      CLR_ALL: begin
        if (cnt == ALL_CELLS) begin
          state_next = IDLE;
        end else begin
          wr_en_next   = 1'b1;
          wr_addr_next = ADDR_W'(cnt);
          wr_data_next = CLEAR_CELL;
          cnt_next     = cnt + CNT_W'(1);
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      state    <= CLR_ALL;
      cnt      <= '0;
      cursor_x <= 6'd0;
      cursor_y <= 5'd0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      cursor_x <= cursor_x_next;
      cursor_y <= cursor_y_next;
      wr_en    <= wr_en_next;
      wr_addr  <= wr_addr_next;
      wr_data  <= wr_data_next;
    end
  end

endmodule

// File: tb/tb_console_writer.sv
// Directed bench for console_writer: reset clear, printing, wraps, control codes,
// back-pressure and reset during a form-feed clear.
module tb_console_writer;

  localparam logic [30:0] CLR = {7'h20, 12'hFFF, 12'h000};

  logic        pix_clk = 1'b0;
  logic        rst;
  logic        en;
  logic        in_valid;
  logic [6:0]  in_char;
  logic [11:0] in_char_color;
  logic [11:0] in_back_color;
  logic        in_ready;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [30:0] wr_data;
  logic [5:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        busy;

  int checks = 0;
  int errors = 0;

  console_writer dut (
    .pix_clk       (pix_clk),
    .rst           (rst),
    .en            (en),
    .in_valid      (in_valid),
    .in_char       (in_char),
    .in_char_color (in_char_color),
    .in_back_color (in_back_color),
    .in_ready      (in_ready),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .cursor_x      (cursor_x),
    .cursor_y      (cursor_y),
    .busy          (busy)
  );

  always #5 pix_clk = ~pix_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pix_clk);
    #1;
  endtask

  task automatic check_cursor(input string tag, input int x, input int y);
    check({tag, "_x"}, cursor_x, x);
    check({tag, "_y"}, cursor_y, y);
  endtask

  // Waits (bounded) for in_ready, then presents one character for exactly one edge.
  task automatic send(input logic [6:0] c);
    int n = 0;
    while (!in_ready && n < 3000) begin
      tick();
      n++;
    end
    check("send_ready", in_ready, 1);
    in_valid = 1'b1;
    in_char  = c;
    tick();
    in_valid = 1'b0;
  endtask

  // Called in the cycle before the edge that starts a full clear.
  task automatic full_clear(input string tag);
    for (int i = 0; i < 1200; i++) begin
      tick();
      check({tag, "_wr_en"}, wr_en, 1);
      check({tag, "_addr"}, wr_addr, i);
      check({tag, "_data"}, wr_data, CLR);
    end
    tick();
    check({tag, "_done_wr_en"}, wr_en, 0);
    check({tag, "_done_busy"}, busy, 0);
    check({tag, "_done_ready"}, in_ready, 1);
    check_cursor({tag, "_done_cur"}, 0, 0);
  endtask

  initial begin
    rst           = 1'b1;
    en            = 1'b1;
    in_valid      = 1'b0;
    in_char       = 7'h00;
    in_char_color = 12'h000;
    in_back_color = 12'h000;

    // Reset state and boot clear
    tick();
    tick();
    check("rst_wr_en", wr_en, 0);
    check("rst_busy", busy, 1);
    check("rst_ready", in_ready, 0);
    check("rst_addr", wr_addr, 0);
    check("rst_data", wr_data, 0);
    check_cursor("rst_cur", 0, 0);
    rst = 1'b0;
    full_clear("boot");

    // "AB" back to back
    in_char_color = 12'hF00;
    in_back_color = 12'h00F;
    in_valid      = 1'b1;
    in_char       = 7'h41;
    tick();
    check("a_wr_en", wr_en, 1);
    check("a_addr", wr_addr, 0);
    check("a_data", wr_data, {7'h41, 12'hF00, 12'h00F});
    check("a_ready", in_ready, 1);
    in_char = 7'h42;
    tick();
    in_valid = 1'b0;
    check("b_wr_en", wr_en, 1);
    check("b_addr", wr_addr, 1);
    check("b_data", wr_data, {7'h42, 12'hF00, 12'h00F});
    check_cursor("ab_cur", 2, 0);
    tick();
    check("ab_idle_wr_en", wr_en, 0);

    // Column wrap from (39,5)
    repeat (5) send(7'h0A);
    repeat (39) send(7'h61);
    check_cursor("pre_wrap_cur", 39, 5);
    send(7'h5A);
    check("cw_wr_en", wr_en, 1);
    check("cw_addr", wr_addr, 239);
    check("cw_data", wr_data, {7'h5A, 12'hF00, 12'h00F});
    check("cw_ready", in_ready, 0);
    check_cursor("cw_cur", 0, 6);
    for (int j = 0; j < 40; j++) begin
      tick();
      check("cw_clr_wr_en", wr_en, 1);
      check("cw_clr_addr", wr_addr, 240 + j);
      check("cw_clr_data", wr_data, CLR);
      check("cw_clr_ready", in_ready, 0);
    end
    tick();
    check("cw_end_ready", in_ready, 1);
    check("cw_end_wr_en", wr_en, 0);

    // Row wrap from (3,29) with newline
    repeat (23) send(7'h0A);
    repeat (3) send(7'h63);
    check_cursor("pre_rw_cur", 3, 29);
    send(7'h0A);
    check("rw_wr_en", wr_en, 0);
    check_cursor("rw_cur", 0, 0);
    for (int j = 0; j < 40; j++) begin
      tick();
      check("rw_clr_wr_en", wr_en, 1);
      check("rw_clr_addr", wr_addr, j);
    end
    tick();
    check("rw_end_wr_en", wr_en, 0);
    check("rw_end_ready", in_ready, 1);

    // Backspace at column 0, then after a character
    repeat (2) send(7'h0A);
    send(7'h08);
    check("bs0_wr_en", wr_en, 0);
    check_cursor("bs0_cur", 0, 2);
    send(7'h78);
    check("x_wr_en", wr_en, 1);
    check("x_addr", wr_addr, 80);
    check("x_data", wr_data, {7'h78, 12'hF00, 12'h00F});
    check_cursor("x_cur", 1, 2);
    send(7'h08);
    check("bs_wr_en", wr_en, 1);
    check("bs_addr", wr_addr, 80);
    check("bs_data", wr_data, CLR);
    check_cursor("bs_cur", 0, 2);

    // Carriage return and discarded codes
    send(7'h71);
    send(7'h0D);
    check("cr_wr_en", wr_en, 0);
    check_cursor("cr_cur", 0, 2);
    send(7'h71);
    send(7'h7F);
    check("del_wr_en", wr_en, 0);
    check_cursor("del_cur", 1, 2);
    send(7'h01);
    check("ctl_wr_en", wr_en, 0);
    check_cursor("ctl_cur", 1, 2);

    // en low holds off acceptance
    en       = 1'b0;
    in_valid = 1'b1;
    in_char  = 7'h41;
    repeat (3) begin
      tick();
      check("en0_ready", in_ready, 0);
      check("en0_wr_en", wr_en, 0);
    end
    check_cursor("en0_cur", 1, 2);
    in_valid = 1'b0;
    en       = 1'b1;

    // Form feed, en dropped mid-clear, then reset at clear cycle 500
    send(7'h0C);
    check("ff_wr_en", wr_en, 1);
    check("ff_addr", wr_addr, 0);
    check("ff_data", wr_data, CLR);
    check("ff_busy", busy, 1);
    check_cursor("ff_cur", 0, 0);
    for (int i = 1; i < 500; i++) begin
      if (i == 100) en = 1'b0;
      if (i == 200) en = 1'b1;
      tick();
      check("ff_clr_wr_en", wr_en, 1);
      check("ff_clr_addr", wr_addr, i);
    end
    rst = 1'b1;
    check("ffr_ready_comb", in_ready, 0);
    tick();
    check("ffr_wr_en", wr_en, 0);
    check("ffr_busy", busy, 1);
    check("ffr_ready", in_ready, 0);
    check_cursor("ffr_cur", 0, 0);
    tick();
    check("ffr_hold_wr_en", wr_en, 0);
    rst = 1'b0;
    full_clear("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/console_writer.md
# console_writer

Writer side of the text display path: accepts a stream of 7-bit character codes with per-character colours and stores them into the character buffer RAM that the pixel generator reads each frame. It keeps a text cursor, interprets a small set of control codes, and wraps at screen edges. Row clears and full-screen clears are done by walking the buffer one cell per clock, with the input held off while a clear runs.

## Interface
Parameters:
- COLS, 40, text columns (640 px / 16 px tiles)
- ROWS, 30, text rows (480 px / 16 px tiles)
- ADDR_W, 11, buffer address width; must satisfy 2^ADDR_W >= COLS*ROWS
- CLR_CHAR_COLOR, 12'hFFF, char colour written by clears
- CLR_BACK_COLOR, 12'h000, back colour written by clears

Ports:
- pix_clk  in  1  clock; one clock for the whole block, no other clock domains
- rst  in  1  reset; synchronous, active-high
- en  in  1  input enable; gates acceptance only
- in_valid  in  1  character available
- in_char  in  7  character code
- in_char_color  in  12  foreground colour
- in_back_color  in  12  background colour
- in_ready  out  1  combinational: (state==IDLE) && en && ~rst
- wr_en  out  1  buffer write strobe, registered
- wr_addr  out  ADDR_W  cell address = row*COLS + col, registered
- wr_data  out  31  {char[30:24], char_color[23:12], back_color[11:0]}, registered
- cursor_x  out  6  current column, 0..COLS-1
- cursor_y  out  5  current row, 0..ROWS-1
- busy  out  1  high in CLR_ROW or CLR_ALL

## Operation
- States: IDLE, CLR_ROW, CLR_ALL.
- Reset values: state=CLR_ALL, clear counter=0, cursor (0,0), wr_en=0, wr_addr=0, wr_data=0, busy=1. in_ready is 0 while rst is high.
- A handshake occurs when in_valid && in_ready. The accepted code is classified as follows:
  - Printable (0x20..0x7E):
    - Write {in_char, in_char_color, in_back_color} at (cursor_x, cursor_y).
    - Advance cursor_x by 1.
    - If cursor_x was COLS-1, set cursor_x=0 and advance the row.
  - 0x0A newline: cursor_x=0, advance the row. No write.
  - 0x0D carriage return: cursor_x=0. No write.
  - 0x08 backspace:
    - If cursor_x>0, decrement cursor_x and write a clear cell (0x20 in the clear colours) at the new position.
    - If cursor_x==0, no-op.
  - 0x0C form feed: cursor to (0,0), enter CLR_ALL.
  - Any other code (0x00..0x1F not listed above, and 0x7F): accepted and discarded. No write, no cursor change.
- Row advance:
  - cursor_y increments, wrapping from ROWS-1 to 0. No scrolling.
  - Every row advance enters CLR_ROW for the new cursor_y.
- CLR_ROW: writes clear cells to col 0..COLS-1 of the target row, one per clock, then returns to IDLE.
- CLR_ALL: writes clear cells to addresses 0..COLS*ROWS-1, one per clock, then returns to IDLE.
- Clear cell = {7'h20, CLR_CHAR_COLOR, CLR_BACK_COLOR}.
- en low:
  - in_ready is held at 0.
  - Clears in progress run to completion.
  - The cursor is held.
- Address arithmetic is unsigned ADDR_W bits. Addresses >= COLS*ROWS are never driven.

## Timing
- Printable or backspace accepted at edge k: wr_en=1 with address/data during cycle k+1. The cursor is updated at edge k. Throughput is 1 character/clock in IDLE.
- Row advance accepted at edge k (wrapping printable or newline):
  - The printable's own write, if any, appears in cycle k+1.
  - Row-clear writes appear in cycles k+2..k+COLS+1, for col 0..COLS-1.
  - state=IDLE after edge k+COLS+1.
  - in_ready is low for cycles k+1..k+COLS+1.
- Form feed accepted at edge k: clear writes for addresses 0..COLS*ROWS-1 appear in cycles k+1..k+COLS*ROWS. in_ready returns in cycle k+COLS*ROWS+1.
- After reset deasserts at edge r:
  - Clear writes for addresses 0..1199 appear in cycles r+1..r+1200.
  - busy falls and in_ready rises in cycle r+1201, when en=1.
- wr_en is 0 in every cycle not listed above.
- rst asserted mid-clear or mid-stream: the current operation is abandoned, all state returns to reset values at that edge, and a full clear restarts.

## Test plan
- Reset clear: pulse rst, en=1 → exactly 1200 writes, addr 0..1199 contiguous, data 31'h20FFF000; in_ready high afterward; cursor (0,0).
- Print "AB" with char colour 12'hF00, back colour 12'h00F, in_valid held → writes {0x41,F00,00F}@0 and {0x42,F00,00F}@1 on consecutive cycles; cursor (2,0).
- Column wrap: cursor (39,5), send 'Z' → write @239; cursor (0,6); 40 clear writes at addr 240..279; in_ready low for 41 cycles.
- Row wrap: cursor (3,29), send 0x0A → no char write; clear writes at addr 0..39; cursor (0,0).
- Backspace: cursor (0,2), send 0x08 → no write. Then send 'x', 0x08 → write 'x'@80, then clear cell @80; cursor (0,2).
- Back-pressure/reset: en=0 with in_valid=1 → no accept, no write. Send 0x0C, then assert rst at cycle 500 of the clear → writes stop; after rst falls, a fresh full clear starts at addr 0.
